// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - hazard scoreboard: load-use stall and registered forward selects
// Optional statistics counters are enabled with SCOREBOARD_STATS_EN.
module pipe_scoreboard #(
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int SW    = $clog2(DEPTH),
  parameter int CNTW  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  input  logic                issue_we_i,
  input  logic [AW-1:0]       issue_rd_i,
  input  logic [LW-1:0]       issue_lat_i,
  input  logic                flush_i,
  input  logic [NREAD-1:0]    rv_i,
  input  logic [NREAD*AW-1:0] ra_i,
  output logic                stall_o,
  output logic [NREAD*SW-1:0] fwd_sel_o,
  output logic [DEPTH-1:0]    slot_valid_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [CNTW-1:0]     stall_cnt_o,
  output logic [CNTW-1:0]     fwd_cnt_o
`endif
);

  if (DEPTH < 2 || CNTW < 1) begin : g_bad_params
  end

  logic [DEPTH-1:0]    v_q, v_d;
  logic [DEPTH-1:0]    we_q, we_d;
  logic [AW-1:0]       rd_q [DEPTH];
  logic [AW-1:0]       rd_d [DEPTH];
  logic [LW-1:0]       lat_q [DEPTH];
  logic [LW-1:0]       lat_d [DEPTH];
  logic [NREAD*SW-1:0] fwd_sel_q, fwd_sel_d;

  logic [DEPTH-1:0]    writer;
  logic [NREAD-1:0]    match_found;
  logic [SW-1:0]       match_idx [NREAD];
  logic [NREAD-1:0]    hazard;
  logic                issue_load;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      writer[i] = v_q[i] & we_q[i] & (rd_q[i] != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching writer overrides.
  always_comb begin
    match_found = '0;
    hazard      = '0;
    for (int p = 0; p < NREAD; p++) begin
      match_idx[p] = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rv_i[p] && (ra_i[p*AW +: AW] != '0) && writer[i] &&
            (rd_q[i] == ra_i[p*AW +: AW])) begin
          match_found[p] = 1'b1;
          match_idx[p]   = SW'(i);
        end
      end
      hazard[p] = match_found[p] &&
                  ((LW'(match_idx[p]) + LW'(1)) < lat_q[match_idx[p]]);
    end
  end

  always_comb begin
    stall_o    = issue_valid_i & ~flush_i & (|hazard);
    issue_load = issue_valid_i & ~stall_o & ~flush_i;
  end

  always_comb begin
    fwd_sel_d = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (match_found[p] && !hazard[p] && !stall_o && !flush_i &&
          (match_idx[p] != SW'(DEPTH - 1))) begin
        fwd_sel_d[p*SW +: SW] = match_idx[p] + SW'(1);
      end
    end
  end

  always_comb begin
    v_d      = '0;
    we_d     = '0;
    v_d[0]   = issue_load;
    we_d[0]  = issue_we_i;
    rd_d[0]  = issue_rd_i;
    lat_d[0] = (issue_lat_i == '0) ? LW'(1) : issue_lat_i;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]   = v_q[i-1];
      we_d[i]  = we_q[i-1];
      rd_d[i]  = rd_q[i-1];
      lat_d[i] = lat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      we_q      <= '0;
      fwd_sel_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      v_q       <= v_d;
      we_q      <= we_d;
      fwd_sel_q <= fwd_sel_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= rd_d[i];
        lat_q[i] <= lat_d[i];
      end
    end
  end

  assign fwd_sel_o    = fwd_sel_q;
  assign slot_valid_o = v_q;

`ifdef SCOREBOARD_STATS_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNTW:0]   fwd_sum;
  int              nfwd;

  always_comb begin
    nfwd = 0;
    for (int p = 0; p < NREAD; p++) begin
      if (fwd_sel_d[p*SW +: SW] != '0) nfwd = nfwd + 1;
    end
    stall_cnt_d = (stall_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
    fwd_sum     = {1'b0, fwd_cnt_q} + (CNTW+1)'(nfwd);
    fwd_cnt_d   = fwd_sum[CNTW] ? '1 : fwd_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed self-checking bench for pipe_scoreboard
// Counter checks run only when SCOREBOARD_STATS_EN is defined.
module tb_pipe_scoreboard;
  localparam int AW = 5, NREAD = 2, DEPTH = 3, LW = 2, SW = 2, CNTW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid_i, issue_we_i, flush_i;
  logic [AW-1:0]       issue_rd_i;
  logic [LW-1:0]       issue_lat_i;
  logic [NREAD-1:0]    rv_i;
  logic [NREAD*AW-1:0] ra_i;
  logic                stall_o;
  logic [NREAD*SW-1:0] fwd_sel_o;
  logic [DEPTH-1:0]    slot_valid_o;
`ifdef SCOREBOARD_STATS_EN
  logic [CNTW-1:0]     stall_cnt_o, fwd_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pipe_scoreboard #(.AW(AW), .NREAD(NREAD), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_we_i    (issue_we_i),
    .issue_rd_i    (issue_rd_i),
    .issue_lat_i   (issue_lat_i),
    .flush_i       (flush_i),
    .rv_i          (rv_i),
    .ra_i          (ra_i),
    .stall_o       (stall_o),
    .fwd_sel_o     (fwd_sel_o),
    .slot_valid_o  (slot_valid_o)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .fwd_cnt_o     (fwd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] rd,
                       input logic [LW-1:0] lat, input logic [1:0] rv,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    issue_valid_i = v;
    issue_we_i    = we;
    issue_rd_i    = rd;
    issue_lat_i   = lat;
    rv_i          = rv;
    ra_i          = {a1, a0};
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    tick(); tick();
    rst = 1'b0;
    check("reset_slot_valid", 32'(slot_valid_o), 0);
    check("reset_fwd_sel", 32'(fwd_sel_o), 0);
    check("reset_stall", 32'(stall_o), 0);

    // ALU back-to-back
    drive(1, 1, 5, 1, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b01, 5, 0);
    check("alu_stall", 32'(stall_o), 0);
    tick();
    check("alu_fwd", 32'(fwd_sel_o), 32'h1);
    drain();

    // load-use
    drive(1, 1, 6, 2, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b10, 0, 6);
    check("lu_stall", 32'(stall_o), 1);
    tick();
    check("lu_bubble", 32'(slot_valid_o), 32'b010);
    check("lu_retry_stall", 32'(stall_o), 0);
    tick();
    check("lu_fwd", 32'(fwd_sel_o), 32'h8);
    check("lu_slots", 32'(slot_valid_o), 32'b101);
    drain();

    // distance 2 forwards from slot 1
    drive(1, 1, 8, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 9, 1, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b01, 8, 0);
    check("dist2_stall", 32'(stall_o), 0);
    tick();
    check("dist2_fwd", 32'(fwd_sel_o), 32'h2);
    drain();

    // distance 3 reads through the write-first register file
    drive(1, 1, 10, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 12, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 13, 1, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b01, 10, 0);
    tick();
    check("dist3_fwd", 32'(fwd_sel_o), 0);
    drain();

    // x0 is never a hazard source
    drive(1, 1, 0, 2, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b11, 0, 0);
    check("x0_stall", 32'(stall_o), 0);
    tick();
    check("x0_fwd", 32'(fwd_sel_o), 0);
    drain();

    // youngest writer wins
    drive(1, 1, 7, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 7, 1, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b11, 7, 7);
    check("young_stall", 32'(stall_o), 0);
    tick();
    check("young_fwd", 32'(fwd_sel_o), 32'h5);
    drain();

    // lat = DEPTH never forwards: lat-1 stall cycles then register-file read
    drive(1, 1, 11, 3, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b01, 11, 0);
    check("lat3_stall_a", 32'(stall_o), 1);
    tick();
    check("lat3_stall_b", 32'(stall_o), 1);
    tick();
    check("lat3_stall_c", 32'(stall_o), 0);
    tick();
    check("lat3_fwd", 32'(fwd_sel_o), 0);
    drain();

    // flush beats a hazard
    drive(1, 1, 6, 2, 2'b00, 0, 0); tick();
    flush_i = 1'b1;
    drive(1, 0, 0, 1, 2'b01, 6, 0);
    check("flush_stall", 32'(stall_o), 0);
    tick();
    flush_i = 1'b0;
    check("flush_bubble", 32'(slot_valid_o), 32'b010);
    check("flush_fwd", 32'(fwd_sel_o), 0);
    drain();

    // reset with all slots valid
    drive(1, 1, 12, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 13, 1, 2'b00, 0, 0); tick();
    drive(1, 1, 14, 1, 2'b01, 13, 0); tick();
    check("full_slots", 32'(slot_valid_o), 32'b111);
    check("full_fwd", 32'(fwd_sel_o), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_slots", 32'(slot_valid_o), 0);
    check("rst_fwd", 32'(fwd_sel_o), 0);
    drain();

`ifdef SCOREBOARD_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    check("stats_rst_stall", 32'(stall_cnt_o), 0);
    check("stats_rst_fwd", 32'(fwd_cnt_o), 0);
    drive(1, 1, 7, 1, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b11, 7, 7); tick();
    drive(1, 1, 11, 3, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b01, 11, 0); tick(); tick(); tick();
    drive(1, 1, 6, 2, 2'b00, 0, 0); tick();
    drive(1, 0, 0, 1, 2'b10, 0, 6); tick();
    drain();
    check("stats_stall_cnt", 32'(stall_cnt_o), 3);
    check("stats_fwd_cnt", 32'(fwd_cnt_o), 2);
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 7, 1, 2'b00, 0, 0); tick();
      drive(1, 0, 0, 1, 2'b11, 7, 7); tick();
      drive(1, 1, 11, 3, 2'b00, 0, 0); tick();
      drive(1, 0, 0, 1, 2'b01, 11, 0); tick(); tick(); tick();
    end
    drain();
    check("stats_stall_sat", 32'(stall_cnt_o), 15);
    check("stats_fwd_sat", 32'(fwd_cnt_o), 15);
    rst = 1'b1; tick(); rst = 1'b0;
    check("stats_clr_stall", 32'(stall_cnt_o), 0);
    check("stats_clr_fwd", 32'(fwd_cnt_o), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
